sb_cfg_loader: RTL and testbench

Serial configuration loader for the switch-box routing matrix. It receives a framed, checksummed configuration bitstream one bit per accepted handshake and assembles the 6-bit routing words for every top, bottom, left and right pin into a shadow store. On a valid frame it commits all words atomically to the parallel configuration bus that drives the matrix's per-pin select registers. The block sits between the fabric configuration port and each switch-box instance.

---
 rtl/sb_cfg_loader.sv | 265 ++++++++++++++++++++++++++
 tb/tb_sb_cfg_loader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_cfg_loader.sv
// Serial, framed and checksummed configuration loader for the switch-box routing matrix.
// Define CFG_READBACK_EN to add the serial readback port (rb_req/rb_valid/rb_bit).
module sb_cfg_loader #(
  parameter int NTB    = 5,
  parameter int NLR    = 4,
  parameter int WORD_W = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_start,
  input  logic                             cfg_valid,
  input  logic                             cfg_bit,
  output logic                             cfg_ready,
  output logic                             cfg_busy,
  output logic                             cfg_done,
  output logic                             cfg_err,
  output logic [WORD_W*(2*NTB+2*NLR)-1:0]  cfg_bus
`ifdef CFG_READBACK_EN
  ,
  input  logic                             rb_req,
  output logic                             rb_valid,
  output logic                             rb_bit
`endif
);
  localparam int         NW       = 2*NTB + 2*NLR;
  localparam int         BW       = WORD_W*NW;
  localparam logic [6:0] LAST_BIT = 7'(BW - 1);
  localparam logic [2:0] LAST_WB  = 3'(WORD_W - 1);
  localparam logic [7:0] SYNC_PAT = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SYNC   = 3'd1,
    S_LOAD   = 3'd2,
    S_CHECK  = 3'd3,
    S_COMMIT = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [6:0]          sync_q, sync_d;
  logic [7:0]          sync_full_s;
  logic [BW-1:0]       shadow_q, shadow_d, bus_q, bus_d;
  logic [6:0]          bit_cnt_q, bit_cnt_d, wr_idx_s;
  logic [4:0]          widx_q, widx_d;
  logic [2:0]          wbit_q, wbit_d, chk_cnt_q, chk_cnt_d;
  logic [WORD_W-2:0]   word_q, word_d, chk_q, chk_d;
  logic [WORD_W-1:0]   word_full_s, chk_full_s, xor_q, xor_d;
  logic                illegal_q, illegal_d;
  logic                ready_q, ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                accept_s, start_s;

  assign accept_s    = cfg_valid && ready_q;
  assign sync_full_s = {sync_q, cfg_bit};
  assign word_full_s = {word_q, cfg_bit};
  assign chk_full_s  = {chk_q, cfg_bit};
  // Words arrive MSB first but are stored low word first.
  assign wr_idx_s    = 7'(widx_q) * 7'(WORD_W) + 7'(LAST_WB - wbit_q);

  // Frame FSM next state, shadow/checksum datapath and pulse outputs
  always_comb begin
    state_d   = state_q;
    sync_d    = sync_q;
    shadow_d  = shadow_q;
    bit_cnt_d = bit_cnt_q;
    widx_d    = widx_q;
    wbit_d    = wbit_q;
    word_d    = word_q;
    xor_d     = xor_q;
    illegal_d = illegal_q;
    chk_d     = chk_q;
    chk_cnt_d = chk_cnt_q;
    bus_d     = bus_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    if (start_s) begin
      state_d   = S_SYNC;
      sync_d    = 7'd0;
      shadow_d  = {BW{1'b0}};
      bit_cnt_d = 7'd0;
      widx_d    = 5'd0;
      wbit_d    = 3'd0;
      word_d    = {(WORD_W-1){1'b0}};
      xor_d     = {WORD_W{1'b0}};
      illegal_d = 1'b0;
      chk_d     = {(WORD_W-1){1'b0}};
      chk_cnt_d = 3'd0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_SYNC: begin
          if (accept_s) begin
            sync_d = sync_full_s[6:0];
            if (sync_full_s == SYNC_PAT) state_d = S_LOAD;
            else                         state_d = S_SYNC;
          end else begin
            state_d = S_SYNC;
          end
        end
        S_LOAD: begin
          if (accept_s) begin
            shadow_d[wr_idx_s] = cfg_bit;
            word_d = word_full_s[WORD_W-2:0];
            if (wbit_q == LAST_WB) begin
              xor_d  = xor_q ^ word_full_s;
              wbit_d = 3'd0;
              widx_d = widx_q + 5'd1;
              if (word_full_s[2:0] > 3'd4) illegal_d = 1'b1;
              else                         illegal_d = illegal_q;
            end else begin
              wbit_d = wbit_q + 3'd1;
            end
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d = 7'd0;
              state_d   = S_CHECK;
            end else begin
              bit_cnt_d = bit_cnt_q + 7'd1;
            end
          end else begin
            state_d = S_LOAD;
          end
        end
        S_CHECK: begin
          if (accept_s) begin
            chk_d = chk_full_s[WORD_W-2:0];
            if (chk_cnt_q == LAST_WB) begin
              chk_cnt_d = 3'd0;
              if ((chk_full_s == xor_q) && !illegal_q) begin
                state_d = S_COMMIT;
              end else begin
                state_d = S_IDLE;
                err_d   = 1'b1;
              end
            end else begin
              chk_cnt_d = chk_cnt_q + 3'd1;
            end
          end else begin
            state_d = S_CHECK;
          end
        end
        S_COMMIT: begin
          bus_d   = shadow_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    ready_d = (state_d == S_SYNC) || (state_d == S_LOAD) || (state_d == S_CHECK);
    busy_d  = (state_d != S_IDLE);
  end

  // Frame FSM state, datapath and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sync_q    <= 7'd0;
      shadow_q  <= {BW{1'b0}};
      bus_q     <= {BW{1'b0}};
      bit_cnt_q <= 7'd0;
      widx_q    <= 5'd0;
      wbit_q    <= 3'd0;
      word_q    <= {(WORD_W-1){1'b0}};
      xor_q     <= {WORD_W{1'b0}};
      illegal_q <= 1'b0;
      chk_q     <= {(WORD_W-1){1'b0}};
      chk_cnt_q <= 3'd0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      shadow_q  <= shadow_d;
      bus_q     <= bus_d;
      bit_cnt_q <= bit_cnt_d;
      widx_q    <= widx_d;
      wbit_q    <= wbit_d;
      word_q    <= word_d;
      xor_q     <= xor_d;
      illegal_q <= illegal_d;
      chk_q     <= chk_d;
      chk_cnt_q <= chk_cnt_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign cfg_ready = ready_q;
  assign cfg_busy  = busy_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign cfg_bus   = bus_q;

`ifdef CFG_READBACK_EN
  localparam logic [4:0] RB_END_W = 5'(NW);

  logic [BW-1:0] rb_sr_q, rb_sr_d;
  logic [4:0]    rb_w_q, rb_w_d;
  logic [2:0]    rb_b_q, rb_b_d;
  logic [6:0]    rb_idx_s;
  logic          rb_valid_q, rb_valid_d, rb_bit_q, rb_bit_d, rb_go_s;

  // A frame start cannot interrupt an active readback.
  assign rb_go_s  = rb_req && (state_q == S_IDLE);
  assign start_s  = cfg_start && !rb_valid_q && !rb_go_s;
  assign rb_idx_s = 7'(rb_w_q) * 7'(WORD_W) + 7'(LAST_WB - rb_b_q);

  // Readback sequencer: word 0 MSB first through the last word
  always_comb begin
    rb_sr_d    = rb_sr_q;
    rb_w_d     = rb_w_q;
    rb_b_d     = rb_b_q;
    rb_valid_d = rb_valid_q;
    rb_bit_d   = rb_bit_q;
    if (rb_go_s) begin
      rb_sr_d    = bus_q;
      rb_valid_d = 1'b1;
      rb_bit_d   = bus_q[WORD_W-1];
      rb_w_d     = 5'd0;
      rb_b_d     = 3'd1;
    end else if (rb_valid_q) begin
      if (rb_w_q == RB_END_W) begin
        rb_valid_d = 1'b0;
        rb_bit_d   = 1'b0;
      end else begin
        rb_bit_d = rb_sr_q[rb_idx_s];
        if (rb_b_q == LAST_WB) begin
          rb_b_d = 3'd0;
          rb_w_d = rb_w_q + 5'd1;
        end else begin
          rb_b_d = rb_b_q + 3'd1;
        end
      end
    end else begin
      rb_valid_d = 1'b0;
    end
  end

  // Readback registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_sr_q    <= {BW{1'b0}};
      rb_w_q     <= 5'd0;
      rb_b_q     <= 3'd0;
      rb_valid_q <= 1'b0;
      rb_bit_q   <= 1'b0;
    end else begin
      rb_sr_q    <= rb_sr_d;
      rb_w_q     <= rb_w_d;
      rb_b_q     <= rb_b_d;
      rb_valid_q <= rb_valid_d;
      rb_bit_q   <= rb_bit_d;
    end
  end

  assign rb_valid = rb_valid_q;
  assign rb_bit   = rb_bit_q;
`else
  assign start_s = cfg_start;
`endif

endmodule

// File: tb/tb_sb_cfg_loader.sv
// Scoreboard bench for sb_cfg_loader: directed frames push expected done/err events,
// a negedge monitor pops and compares them against cfg_done/cfg_err/cfg_bus.
module tb_sb_cfg_loader;
  localparam int BW = 108;

  logic clk = 1'b0;
  logic rst, cfg_start, cfg_valid, cfg_bit;
  logic cfg_ready, cfg_busy, cfg_done, cfg_err;
  logic [BW-1:0] cfg_bus;
`ifdef CFG_READBACK_EN
  logic rb_req, rb_valid, rb_bit;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          is_done;
    logic [BW-1:0] bus;
  } exp_t;

  exp_t          sb_q[$];
  logic [BW-1:0] committed;
  logic [BW-1:0] f1, f3, f4, f5;

  always #5 clk = ~clk;

  sb_cfg_loader dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_ready (cfg_ready),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .cfg_bus   (cfg_bus)
`ifdef CFG_READBACK_EN
    ,
    .rb_req    (rb_req),
    .rb_valid  (rb_valid),
    .rb_bit    (rb_bit)
`endif
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_done(input logic [BW-1:0] bus);
    exp_t e;
    e.is_done = 1'b1;
    e.bus     = bus;
    sb_q.push_back(e);
    committed = bus;
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_done = 1'b0;
    e.bus     = committed;
    sb_q.push_back(e);
  endtask

  // Monitor: every done/err pulse must match the oldest expected event.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (cfg_done === 1'b1 || cfg_err === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: done=%b err=%b with no event expected", cfg_done, cfg_err);
        end else begin
          e = sb_q.pop_front();
          chk1("pulse_done", cfg_done, e.is_done);
          chk1("pulse_err", cfg_err, !e.is_done);
          chkw("pulse_bus", cfg_bus, e.bus);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b, input int gap);
    int n;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
    end
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_bit   = b;
    n = 0;
    while (cfg_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: cfg_ready=%b expected 1", cfg_ready);
    end
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  function automatic int pick_gap(input int gap_max);
    int g;
    if (gap_max > 0) g = int'($urandom_range(gap_max, 0));
    else             g = 0;
    return g;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    for (int i = 7; i >= 0; i--) send_bit(b[i], pick_gap(gap_max));
  endtask

  task automatic send_load(input logic [BW-1:0] bus, input int nbits, input int gap_max);
    for (int n = 0; n < nbits; n++) send_bit(bus[6*(n/6) + 5 - (n%6)], pick_gap(gap_max));
  endtask

  task automatic full_frame(input logic [BW-1:0] bus, input logic [5:0] csum, input int gap_max);
    send_byte(8'hA5, gap_max);
    send_load(bus, BW, gap_max);
    for (int i = 5; i >= 0; i--) send_bit(csum[i], pick_gap(gap_max));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    cfg_start = 1'b1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    chk1("ready_after_start", cfg_ready, 1'b1);
  endtask

  // Called right after the edge that accepted the last checksum bit.
  task automatic check_latency(input logic exp_done);
    @(negedge clk);
    if (exp_done) begin
      chk1("commit_busy", cfg_busy, 1'b1);
      chk1("commit_not_ready", cfg_ready, 1'b0);
      chk1("done_not_early", cfg_done, 1'b0);
      @(negedge clk);
      chk1("done_latency", cfg_done, 1'b1);
      chkw("bus_after_commit", cfg_bus, committed);
    end else begin
      chk1("err_latency", cfg_err, 1'b1);
      chk1("err_idle", cfg_busy, 1'b0);
      @(negedge clk);
      chk1("err_one_cycle", cfg_err, 1'b0);
    end
  endtask

  initial begin : stimulus
    int bad;
    logic [BW-1:0] exp_rb;
    rst       = 1'b1;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
    committed = {BW{1'b0}};
`ifdef CFG_READBACK_EN
    rb_req    = 1'b0;
`endif
    f1 = {BW{1'b0}};
    f1[5:0] = 6'h13;
    f3 = {BW{1'b0}};
    f3[107:102] = 6'h05;
    f4 = {BW{1'b0}};
    f4[5:0]     = 6'h0C;
    f4[59:54]   = 6'h2A;
    f4[107:102] = 6'h3B;
    f5 = {BW{1'b0}};
    f5[35:30] = 6'h11;
    f5[83:78] = 6'h04;

    repeat (2) @(negedge clk);
    chkw("reset_bus", cfg_bus, {BW{1'b0}});
    chk1("reset_ready", cfg_ready, 1'b0);
    chk1("reset_busy", cfg_busy, 1'b0);
    chk1("reset_done", cfg_done, 1'b0);
    chk1("reset_err", cfg_err, 1'b0);
    rst = 1'b0;

    // Basic frame: top[0] sourced from bottom[2]
    expect_done(f1);
    pulse_start();
    full_frame(f1, 6'h13, 0);
    check_latency(1'b1);

    // Asynchronous reset after 40 LOAD bits
    pulse_start();
    send_byte(8'hA5, 0);
    send_load(f4, 40, 0);
    #2 rst = 1'b1;
    #1;
    chkw("async_reset_bus", cfg_bus, {BW{1'b0}});
    chk1("async_reset_ready", cfg_ready, 1'b0);
    chk1("async_reset_busy", cfg_busy, 1'b0);
    chk1("async_reset_done", cfg_done, 1'b0);
    chk1("async_reset_err", cfg_err, 1'b0);
    committed = {BW{1'b0}};
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk1("idle_after_reset_busy", cfg_busy, 1'b0);
    chk1("idle_after_reset_ready", cfg_ready, 1'b0);

    expect_done(f1);
    pulse_start();
    full_frame(f1, 6'h13, 0);
    check_latency(1'b1);

    // Wrong checksum
    expect_err();
    pulse_start();
    full_frame(f1, 6'h00, 0);
    check_latency(1'b0);

    // right[3] with side 5 and a matching checksum
    expect_err();
    pulse_start();
    full_frame(f3, 6'h05, 0);
    check_latency(1'b0);
    chkw("bus_kept_after_errors", cfg_bus, f1);

    // Garbage before sync, random valid gaps, side 4 at the legality boundary
    expect_done(f4);
    pulse_start();
    send_byte(8'hFF, 1);
    send_byte(8'h5A, 1);
    full_frame(f4, 6'h1D, 2);
    check_latency(1'b1);

    // Restart after 60 LOAD bits, only the second frame commits
    expect_done(f5);
    pulse_start();
    send_byte(8'hA5, 0);
    send_load(f3, 60, 0);
    pulse_start();
    chkw("abort_keeps_bus", cfg_bus, f4);
    full_frame(f5, 6'h15, 0);
    check_latency(1'b1);

`ifdef CFG_READBACK_EN
    expect_done(f1);
    pulse_start();
    full_frame(f1, 6'h13, 0);
    check_latency(1'b1);
    exp_rb = {6'b010011, 102'd0};
    @(negedge clk);
    rb_req = 1'b1;
    @(posedge clk);
    #1;
    rb_req = 1'b0;
    bad = 0;
    for (int i = 0; i < BW; i++) begin
      @(negedge clk);
      if (rb_valid !== 1'b1 || rb_bit !== exp_rb[BW-1-i]) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL readback_stream: %0d bad positions, expected 0", bad);
    end
    @(negedge clk);
    chk1("readback_end", rb_valid, 1'b0);
    chkw("readback_bus_unchanged", cfg_bus, f1);
`else
    bad = 0;
    exp_rb = {BW{1'b0}};
`endif

    repeat (5) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: %0d events never seen, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
